// File: rtl/cla_nibble_sub.sv
// Multi-cycle borrow look-ahead subtractor: D = A - B - bin, one nibble per clock,
// LSB nibble first, with the inter-nibble borrow held in a register.
module cla_nibble_sub #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef USE_POWER_PINS
    inout  wire                    vdd,
    inout  wire                    vss,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   D,
    output logic                   bout,
    output logic                   ovf,
    output logic                   zero
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            borrow_q, borrow_d;
    logic [W-1:0]    d_q, d_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;

    // Subtract slice as A + ~B + carry, carry-in is the inverted borrow.
    // Returns {borrow_out, diff}; every carry is a flat sum of products of c0.
    function automatic logic [4:0] cla4_sub(input logic [3:0] a, input logic [3:0] b,
                                            input logic bi);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a ^ ~b;
        g    = a & ~b;
        c[0] = ~bi;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {~c[4], p ^ c[3:0]};
    endfunction

    logic [CntW+1:0] sh;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [4:0]      slice;
    logic [W-1:0]    nib_mask;

    assign sh       = {cnt_q, 2'b00};
    assign a_nib    = 4'(a_q >> sh);
    assign b_nib    = 4'(b_q >> sh);
    assign slice    = cla4_sub(a_nib, b_nib, borrow_q);
    assign nib_mask = W'(4'hF) << sh;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        borrow_d    = borrow_q;
        d_d         = d_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                d_d      = (d_q & ~nib_mask) | (W'(slice[3:0]) << sh);
                borrow_d = slice[4];
                if (cnt_q == LastCnt) begin
                    // Flags are taken from the completed word on the same edge.
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    bout_d      = slice[4];
                    zero_d      = (d_d == '0);
                    ovf_d       = (a_q[W-1] != b_q[W-1]) && (d_d[W-1] != a_q[W-1]);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            borrow_q    <= borrow_d;
            d_q         <= d_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_nibble_sub.sv
// Bench for cla_nibble_sub: directed vectors plus randomized ops checked against
// an arithmetic reference model via a per-cycle compare process.
module tb_cla_nibble_sub;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d_out;
    logic         bout;
    logic         ovf;
    logic         zero;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];

    cla_nibble_sub #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .B         (b_in),
        .bin       (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (d_out),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bi);
        exp_t   e;
        longint diff;
        diff   = longint'(a) - longint'(b) - longint'(bi);
        e.d    = W'(diff);
        e.bout = (longint'(a) < longint'(b) + longint'(bi));
        e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        e.zero = (e.d == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard push on accepted operands, pop on result handshake.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) exp_q.push_back(model(a_in, b_in, bin_in));
        if (rst_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    // Result must match the model on every cycle it is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got 1, expected 0");
            end else begin
                chk("D", 64'(d_out), 64'(exp_q[0].d));
                chk("bout", 64'(bout), 64'(exp_q[0].bout));
                chk("ovf", 64'(ovf), 64'(exp_q[0].ovf));
                chk("zero", 64'(zero), 64'(exp_q[0].zero));
            end
        end
    end

    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
        end
        a_in     = a;
        b_in     = b;
        bin_in   = bi;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic finish_op(input int hold);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!out_valid && n < 20);
        chk("latency", 64'(n), 64'(NIBBLES));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            bin_in   = 1'($urandom_range(0, 1));
            #1 chk("in_ready_busy", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("out_valid_drop", 64'(out_valid), 64'd0);
        chk("in_ready_back", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                            input int hold, input logic [W-1:0] ed, input logic ebout,
                            input logic eovf, input logic ezero);
        exp_t e;
        e = model(a, b, bi);
        chk("model_d", 64'(e.d), 64'(ed));
        chk("model_bout", 64'(e.bout), 64'(ebout));
        chk("model_ovf", 64'(e.ovf), 64'(eovf));
        accept_op(a, b, bi);
        finish_op(hold);
        chk("lit_D", 64'(d_out), 64'(ed));
        chk("lit_bout", 64'(bout), 64'(ebout));
        chk("lit_ovf", 64'(ovf), 64'(eovf));
        chk("lit_zero", 64'(zero), 64'(ezero));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        bin_in    = 1'b0;
        #12;
        chk("rst_D", 64'(d_out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'({bout, ovf, zero}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        directed(16'h1234, 16'h0234, 1'b0, 0, 16'h1000, 1'b0, 1'b0, 1'b0);
        directed(16'h0000, 16'h0001, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        directed(16'h8000, 16'h0001, 1'b0, 1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        directed(16'h7FFF, 16'hFFFF, 1'b0, 0, 16'h8000, 1'b1, 1'b1, 1'b0);
        directed(16'h5A5A, 16'h5A5A, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1);
        directed(16'h5A5A, 16'h5A5A, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        // Backpressure with ignored operands, then a clean follow-up op.
        directed(16'h00FF, 16'h0F0F, 1'b1, 5, 16'hF1EF, 1'b1, 1'b0, 1'b0);
        directed(16'h0003, 16'h0005, 1'b0, 0, 16'hFFFE, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while nibble 2 is pending.
        accept_op(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_D", 64'(d_out), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_flags", 64'({bout, ovf, zero}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_ghost_out_valid", 64'(out_valid), 64'd0);
        end
        directed(16'h0010, 16'h0001, 1'b0, 0, 16'h000F, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            accept_op(ra, rb, 1'($urandom_range(0, 1)));
            finish_op(int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
